// File: rtl/mem_stage_if.sv
// EX/MEM -> MEM/WB pipeline boundary of the memory stage.
// The master side is the upstream pipeline: it drives the EX_MEM_* fields
// and must hold them stable while mem_stall is high.
interface mem_stage_if;
    logic        EX_MEM_valid;
    logic [31:0] EX_MEM_alures;
    logic [31:0] EX_MEM_alusec;
    logic        EX_MEM_regwrite;
    logic        EX_MEM_memread;
    logic        EX_MEM_memwrite;
    logic [2:0]  EX_MEM_funct3;
    logic [4:0]  EX_MEM_rd;

    logic        MEM_WB_valid;
    logic        MEM_WB_regwrite;
    logic        MEM_WB_memread;
    logic [4:0]  MEM_WB_rd;
    logic [31:0] MEM_WB_alures;
    logic [31:0] MEM_WB_memres;
    logic        MEM_WB_misalign;
    logic        mem_stall;

    modport master (
        output EX_MEM_valid, EX_MEM_alures, EX_MEM_alusec, EX_MEM_regwrite,
               EX_MEM_memread, EX_MEM_memwrite, EX_MEM_funct3, EX_MEM_rd,
        input  MEM_WB_valid, MEM_WB_regwrite, MEM_WB_memread, MEM_WB_rd,
               MEM_WB_alures, MEM_WB_memres, MEM_WB_misalign, mem_stall
    );

    modport slave (
        input  EX_MEM_valid, EX_MEM_alures, EX_MEM_alusec, EX_MEM_regwrite,
               EX_MEM_memread, EX_MEM_memwrite, EX_MEM_funct3, EX_MEM_rd,
        output MEM_WB_valid, MEM_WB_regwrite, MEM_WB_memread, MEM_WB_rd,
               MEM_WB_alures, MEM_WB_memres, MEM_WB_misalign, mem_stall
    );
endinterface

// File: rtl/mem_stage_param.sv
// Memory pipeline stage with a word-organised data RAM and a configurable
// per-access wait-state count.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | ready; non-access, misaligned or zero-latency ops complete here
// ST_WAIT | aligned access in flight; completes on the edge where cnt == 1
//
// The EX_MEM fields are held by upstream for the whole access, so the
// completion edge uses the live inputs; nothing is latched on entry.
// Loads read the RAM combinationally, so a load right after a store to the
// same word sees the freshly written bytes.
module mem_stage_param #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    mem_stage_if.slave  bus
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [2:0] LAT      = 3'(LATENCY);
    localparam bit         HAS_WAIT = (LATENCY != 0);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t      state;
    logic [2:0]  cnt;

    logic [31:0] mem [DEPTH];

    logic [AW-1:0] idx;
    logic [1:0]    boff;
    logic [2:0]    f3;
    logic          access;
    logic          is_store;
    logic          is_load;
    logic          illegal;
    logic          misalign;
    logic          aligned_acc;
    logic          go_wait;
    logic          complete;
    logic          we;
    logic [31:0]   rword;
    logic [7:0]    rbyte;
    logic [15:0]   rhalf;
    logic [31:0]   load_val;
    logic [31:0]   wdata;
    logic [3:0]    wmask;

    // Decode the access: kind, alignment and the FSM-side handshake terms.
    always_comb begin
        idx         = bus.EX_MEM_alures[AW+1:2];
        boff        = bus.EX_MEM_alures[1:0];
        f3          = bus.EX_MEM_funct3;
        access      = bus.EX_MEM_valid & (bus.EX_MEM_memread | bus.EX_MEM_memwrite);
        is_store    = access & bus.EX_MEM_memwrite;
        is_load     = access & bus.EX_MEM_memread & ~bus.EX_MEM_memwrite;
        illegal     = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        misalign    = illegal
                    || ((f3[1:0] == 2'b01) && boff[0])
                    || ((f3[1:0] == 2'b10) && (boff != 2'b00));
        aligned_acc = access & ~misalign;
        go_wait     = HAS_WAIT && (state == ST_IDLE) && aligned_acc;
        complete    = ((state == ST_IDLE) && !go_wait)
                    || ((state == ST_WAIT) && (cnt == 3'd1));
        // Gated by rst_n so a store can never land while reset is held.
        we          = rst_n && complete && is_store && !misalign;
        bus.mem_stall = rst_n && (go_wait || ((state == ST_WAIT) && (cnt > 3'd1)));
    end

    // Load path: pick the addressed byte/half and extend by funct3.
    always_comb begin
        rword = mem[idx];
        rbyte = rword[{boff, 3'b000} +: 8];
        rhalf = boff[1] ? rword[31:16] : rword[15:0];
        unique case (f3)
            3'b000:  load_val = {{24{rbyte[7]}}, rbyte};
            3'b001:  load_val = {{16{rhalf[15]}}, rhalf};
            3'b010:  load_val = rword;
            3'b100:  load_val = {24'd0, rbyte};
            3'b101:  load_val = {16'd0, rhalf};
            default: load_val = 32'd0;
        endcase
    end

    // Store path: replicate the data across lanes and pick the byte enables.
    always_comb begin
        unique case (f3[1:0])
            2'b00: begin
                wmask = 4'b0001 << boff;
                wdata = {4{bus.EX_MEM_alusec[7:0]}};
            end
            2'b01: begin
                wmask = boff[1] ? 4'b1100 : 4'b0011;
                wdata = {2{bus.EX_MEM_alusec[15:0]}};
            end
            default: begin
                wmask = 4'b1111;
                wdata = bus.EX_MEM_alusec;
            end
        endcase
    end

    // Data RAM: byte-lane writes on the completion edge, contents never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask[i]) begin
                    mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    // Wait-state FSM with the registered MEM/WB outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= ST_IDLE;
            cnt                 <= 3'd0;
            bus.MEM_WB_valid    <= 1'b0;
            bus.MEM_WB_regwrite <= 1'b0;
            bus.MEM_WB_memread  <= 1'b0;
            bus.MEM_WB_rd       <= 5'd0;
            bus.MEM_WB_alures   <= 32'd0;
            bus.MEM_WB_memres   <= 32'd0;
            bus.MEM_WB_misalign <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (go_wait) begin
                        state <= ST_WAIT;
                        cnt   <= LAT;
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= 3'd0;
                end
            endcase

            if (complete) begin
                bus.MEM_WB_valid    <= bus.EX_MEM_valid;
                bus.MEM_WB_regwrite <= bus.EX_MEM_valid & bus.EX_MEM_regwrite
                                       & ~(access & misalign);
                bus.MEM_WB_memread  <= is_load;
                bus.MEM_WB_rd       <= bus.EX_MEM_rd;
                bus.MEM_WB_alures   <= bus.EX_MEM_alures;
                bus.MEM_WB_memres   <= (is_load && !misalign) ? load_val : 32'd0;
                bus.MEM_WB_misalign <= access & misalign;
            end else begin
                bus.MEM_WB_valid    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_param.sv
// Directed bench for mem_stage_param: one instance with no wait states and
// one with two, each checked every cycle against a byte-level memory model.
module tb_mem_stage_param;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_stage_if bus0();
    mem_stage_if bus2();

    mem_stage_param #(.DEPTH(256), .LATENCY(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0.slave)
    );
    mem_stage_param #(.DEPTH(256), .LATENCY(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2.slave)
    );

    typedef struct {
        int          due;
        logic        rw;
        logic        mr;
        logic        mis;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] mres;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   stall0_seen = 0;
    exp_t q0[$];
    exp_t q2[$];
    logic [7:0] mb [2][1024];

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (bus0.mem_stall === 1'b1) stall0_seen = 1;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic check_rec(input string nm, input exp_t e, input logic v, rw, mr, mis,
                             input logic [4:0] rd, input logic [31:0] alu, mres);
        chk({nm, " valid"}, 32'(v), 32'd1);
        chk({nm, " regwrite"}, 32'(rw), 32'(e.rw));
        chk({nm, " memread"}, 32'(mr), 32'(e.mr));
        chk({nm, " misalign"}, 32'(mis), 32'(e.mis));
        chk({nm, " rd"}, 32'(rd), 32'(e.rd));
        chk({nm, " alures"}, alu, e.alu);
        chk({nm, " memres"}, mres, e.mres);
    endtask

    // Every cycle: a due record must appear exactly then, otherwise valid is low.
    always @(negedge clk) begin
        if (q0.size() > 0 && q0[0].due == cyc) begin
            check_rec("dut0", q0.pop_front(), bus0.MEM_WB_valid, bus0.MEM_WB_regwrite,
                      bus0.MEM_WB_memread, bus0.MEM_WB_misalign, bus0.MEM_WB_rd,
                      bus0.MEM_WB_alures, bus0.MEM_WB_memres);
        end else begin
            chk("dut0 idle valid", 32'(bus0.MEM_WB_valid), 32'd0);
        end
        if (q2.size() > 0 && q2[0].due == cyc) begin
            check_rec("dut2", q2.pop_front(), bus2.MEM_WB_valid, bus2.MEM_WB_regwrite,
                      bus2.MEM_WB_memread, bus2.MEM_WB_misalign, bus2.MEM_WB_rd,
                      bus2.MEM_WB_alures, bus2.MEM_WB_memres);
        end else begin
            chk("dut2 idle valid", 32'(bus2.MEM_WB_valid), 32'd0);
        end
    end

    task automatic set_bus(input int sel, input logic v, rw, mr, mw, input logic [2:0] f3,
                           input logic [4:0] rd, input logic [31:0] alu, sec);
        if (sel == 0) begin
            bus0.EX_MEM_valid = v;     bus0.EX_MEM_regwrite = rw;
            bus0.EX_MEM_memread = mr;  bus0.EX_MEM_memwrite = mw;
            bus0.EX_MEM_funct3 = f3;   bus0.EX_MEM_rd = rd;
            bus0.EX_MEM_alures = alu;  bus0.EX_MEM_alusec = sec;
        end else begin
            bus2.EX_MEM_valid = v;     bus2.EX_MEM_regwrite = rw;
            bus2.EX_MEM_memread = mr;  bus2.EX_MEM_memwrite = mw;
            bus2.EX_MEM_funct3 = f3;   bus2.EX_MEM_rd = rd;
            bus2.EX_MEM_alures = alu;  bus2.EX_MEM_alusec = sec;
        end
    endtask

    task automatic idle(input int sel);
        set_bus(sel, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 5'd0, 32'd0, 32'd0);
    endtask

    function automatic logic get_stall(input int sel);
        return (sel == 0) ? bus0.mem_stall : bus2.mem_stall;
    endfunction

    function automatic logic [31:0] get_memres(input int sel);
        return (sel == 0) ? bus0.MEM_WB_memres : bus2.MEM_WB_memres;
    endfunction

    // Model one op, present it, wait out its stall, then leave the bus idle.
    // Entered and left at 1 time unit after a rising edge.
    task automatic run_op(input int sel, input logic v, rw, mr, mw, input logic [2:0] f3,
                          input logic [4:0] rd, input logic [31:0] alu, sec,
                          input bit has_lit, input logic [31:0] lit);
        int a, sz, n, exp_stall;
        bit legal, acc, ld, st, mis;
        logic [31:0] val;
        exp_t e;
        a   = int'(alu[9:0]);
        acc = v && (mr || mw);
        st  = acc && mw;
        ld  = acc && mr && !mw;
        legal = 1;
        case (f3)
            3'b000, 3'b100: sz = 1;
            3'b001, 3'b101: sz = 2;
            3'b010:         sz = 4;
            default: begin sz = 1; legal = 0; end
        endcase
        mis = acc && (!legal || (a % sz) != 0);
        val = 32'd0;
        if (st && !mis)
            for (int i = 0; i < sz; i++) mb[sel][a+i] = sec[8*i +: 8];
        if (ld && !mis) begin
            for (int i = 0; i < sz; i++) val[8*i +: 8] = mb[sel][a+i];
            if (!f3[2] && sz == 1) val = {{24{val[7]}}, val[7:0]};
            if (!f3[2] && sz == 2) val = {{16{val[15]}}, val[15:0]};
        end
        e.rw = v && rw && !mis;
        e.mr = ld;
        e.mis = mis;
        e.rd = rd;
        e.alu = alu;
        e.mres = val;
        exp_stall = (acc && !mis) ? ((sel == 0) ? 0 : 2) : 0;
        e.due = cyc + exp_stall + 1;
        if (v) begin
            if (sel == 0) q0.push_back(e); else q2.push_back(e);
        end
        if (has_lit) chk("model pin", val, lit);
        set_bus(sel, v, rw, mr, mw, f3, rd, alu, sec);
        #1;
        n = 0;
        while (get_stall(sel) === 1'b1 && n < 20) begin
            n++;
            @(posedge clk); #1;
        end
        chk("stall cycles", 32'(n), 32'(exp_stall));
        @(posedge clk); #1;
        if (has_lit) chk("literal memres", get_memres(sel), lit);
        idle(sel);
    endtask

    task automatic st_op(input int sel, input logic [2:0] f3, input logic [31:0] addr, data);
        run_op(sel, 1'b1, 1'b0, 1'b0, 1'b1, f3, 5'd0, addr, data, 1'b0, 32'd0);
    endtask

    task automatic ld_op(input int sel, input logic [2:0] f3, input logic [4:0] rd,
                         input logic [31:0] addr, input logic [31:0] lit);
        run_op(sel, 1'b1, 1'b1, 1'b1, 1'b0, f3, rd, addr, 32'd0, 1'b1, lit);
    endtask

    initial begin
        idle(0);
        idle(1);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // An aligned load presented during reset must not raise stall.
        set_bus(1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 5'd3, 32'h104, 32'd0);
        #1;
        chk("reset stall", 32'(bus2.mem_stall), 32'd0);
        chk("reset valid0", 32'(bus0.MEM_WB_valid), 32'd0);
        chk("reset alures2", bus2.MEM_WB_alures, 32'd0);
        chk("reset memres2", bus2.MEM_WB_memres, 32'd0);
        idle(1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // No wait states.
        st_op(0, 3'b010, 32'h100, 32'hDEADBEEF);
        ld_op(0, 3'b010, 5'd5, 32'h100, 32'hDEADBEEF);
        run_op(0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 5'd7, 32'h12345678, 32'h99, 1'b1, 32'd0);
        run_op(0, 1'b0, 1'b1, 1'b1, 1'b0, 3'b010, 5'd8, 32'h100, 32'd0, 1'b0, 32'd0);
        ld_op(0, 3'b001, 5'd6, 32'h103, 32'd0);
        st_op(0, 3'b010, 32'h102, 32'd0);
        ld_op(0, 3'b010, 5'd8, 32'h100, 32'hDEADBEEF);
        st_op(0, 3'b001, 32'h102, 32'hABCD1234);
        ld_op(0, 3'b101, 5'd9, 32'h102, 32'h00001234);
        ld_op(0, 3'b001, 5'd10, 32'h100, 32'hFFFFBEEF);
        ld_op(0, 3'b011, 5'd11, 32'h100, 32'd0);
        run_op(0, 1'b1, 1'b1, 1'b1, 1'b1, 3'b010, 5'd12, 32'h104, 32'h7, 1'b1, 32'd0);
        ld_op(0, 3'b010, 5'd13, 32'h104, 32'h7);

        // Two wait states.
        st_op(1, 3'b010, 32'h104, 32'hCAFEF00D);
        ld_op(1, 3'b010, 5'd3, 32'h104, 32'hCAFEF00D);
        st_op(1, 3'b010, 32'h100, 32'h11223344);
        st_op(1, 3'b000, 32'h101, 32'h000000F0);
        ld_op(1, 3'b000, 5'd4, 32'h101, 32'hFFFFFFF0);
        ld_op(1, 3'b100, 5'd5, 32'h101, 32'h000000F0);
        ld_op(1, 3'b010, 5'd6, 32'h100, 32'h1122F044);
        ld_op(1, 3'b001, 5'd7, 32'h103, 32'd0);
        ld_op(1, 3'b010, 5'd8, 32'h100, 32'h1122F044);
        st_op(1, 3'b010, 32'h400, 32'h5);
        ld_op(1, 3'b010, 5'd9, 32'h000, 32'h5);
        run_op(1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 5'd10, 32'hA5, 32'd0, 1'b1, 32'd0);
        st_op(1, 3'b010, 32'h108, 32'd0);

        // Reset in the middle of a stalled store aborts it.
        set_bus(1, 1'b1, 1'b0, 1'b0, 1'b1, 3'b010, 5'd0, 32'h108, 32'hA5A5A5A5);
        @(posedge clk); #1;
        chk("mid-wait stall", 32'(bus2.mem_stall), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort stall", 32'(bus2.mem_stall), 32'd0);
        chk("abort valid", 32'(bus2.MEM_WB_valid), 32'd0);
        chk("abort regwrite", 32'(bus2.MEM_WB_regwrite), 32'd0);
        chk("abort memread", 32'(bus2.MEM_WB_memread), 32'd0);
        chk("abort rd", 32'(bus2.MEM_WB_rd), 32'd0);
        chk("abort alures", bus2.MEM_WB_alures, 32'd0);
        chk("abort memres", bus2.MEM_WB_memres, 32'd0);
        chk("abort misalign", 32'(bus2.MEM_WB_misalign), 32'd0);
        idle(1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        ld_op(1, 3'b010, 5'd12, 32'h108, 32'd0);
        run_op(1, 1'b0, 1'b1, 1'b1, 1'b0, 3'b010, 5'd13, 32'h108, 32'd0, 1'b0, 32'd0);

        repeat (3) @(posedge clk);
        #1;
        chk("dut0 queue drained", 32'(q0.size()), 32'd0);
        chk("dut2 queue drained", 32'(q2.size()), 32'd0);
        chk("dut0 never stalled", 32'(stall0_seen), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
